// File: rtl/link_pattern_pkg.sv
// Shared types and the PRBS7 helper for the link test-pattern generator.
// Contents: FSM state enum, payload mode enum, prbs7_step8() which advances
// the x^7+x^6+1 LFSR eight steps and returns {next_state[6:0], byte[7:0]}.
package link_pattern_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRAIN = 2'd1,
      DATA  = 2'd2,
      DONE  = 2'd3
   } lpg_state_t;

   // Mode 3 is reserved and decodes the same as fixed-word.
   typedef enum logic [1:0] {
      MODE_FIXED   = 2'd0,
      MODE_COUNTER = 2'd1,
      MODE_PRBS7   = 2'd2,
      MODE_RSVD    = 2'd3
   } lpg_mode_t;

   // Fibonacci x^7+x^6+1: new = s[6]^s[5], shift left, new bit enters at s[0].
   // The eight new bits form the output byte, first generated bit in the MSB.
   function automatic logic [14:0] prbs7_step8(input logic [6:0] seed);
      logic [6:0] st;
      logic [7:0] b;
      logic       nb;
      st = seed;
      b  = 8'h00;
      for (int i = 0; i < 8; i++) begin
         nb = st[6] ^ st[5];
         st = {st[5:0], nb};
         b  = {b[6:0], nb};
      end
      return {st, b};
   endfunction

endpackage

// File: rtl/prbs7_byte_gen.sv
// PRBS7 byte source: LFSR register with seed load and 8-step advance.
// Ports: clk, rst_n (async active-low), load (reseed), adv (consume current byte),
//        byte_o (byte generated from the effective state, seed when load is high).
module prbs7_byte_gen
   import link_pattern_pkg::*;
#(
   parameter logic [6:0] SEED = 7'h7F
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       adv,
   output logic [7:0] byte_o
);

   logic [6:0]  lfsr_q;
   logic [6:0]  lfsr_d;
   logic [6:0]  lfsr_eff;
   logic [14:0] step;

   // A load in the same cycle as an advance must produce the byte of the
   // freshly loaded seed, so the byte path sees the seed while load is high.
   assign lfsr_eff = load ? SEED : lfsr_q;
   assign step     = prbs7_step8(lfsr_eff);
   assign byte_o   = step[7:0];

   always_comb begin
      lfsr_d = lfsr_q;
      if (adv) begin
         lfsr_d = step[14:8];
      end else if (load) begin
         lfsr_d = SEED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule

// File: rtl/link_pattern_gen.sv
// Transmit-side burst pattern source for one serial link: optional training
// preamble followed by fixed / counter / PRBS7 payload on an 8-bit AXI stream.
// Ports: in_clk160/in_clk160_aresetn clock and async active-low reset;
//        start/stop/mode/fixed_word/train_word/n_train/n_words burst control;
//        m_tdata/m_tvalid/m_tready stream; busy/done/word_count status.
module link_pattern_gen
   import link_pattern_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH = 32,
   parameter int unsigned TRAIN_WIDTH = 16,
   parameter logic [6:0]  PRBS_SEED   = 7'h7F
) (
   input  logic                   in_clk160,
   input  logic                   in_clk160_aresetn,
   input  logic                   start,
   input  logic                   stop,
   input  logic [1:0]             mode,
   input  logic [7:0]             fixed_word,
   input  logic [7:0]             train_word,
   input  logic [TRAIN_WIDTH-1:0] n_train,
   input  logic [COUNT_WIDTH-1:0] n_words,
   output logic [7:0]             m_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] word_count
);

   lpg_state_t             state_q, state_d;
   lpg_mode_t              mode_q, mode_d;
   logic [7:0]             fixed_q, fixed_d;
   logic [7:0]             train_word_q, train_word_d;
   logic [COUNT_WIDTH-1:0] n_words_q, n_words_d;
   logic [COUNT_WIDTH-1:0] data_rem_q, data_rem_d;
   logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
   logic [TRAIN_WIDTH-1:0] train_rem_q, train_rem_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [7:0]             tdata_q, tdata_d;
   logic                   tvalid_q, tvalid_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic                   start_ok;
   logic                   beat;
   logic                   can_present;
   logic                   present_payload;
   logic                   prbs_adv;
   lpg_mode_t              mode_eff;
   logic [7:0]             fixed_eff;
   logic [7:0]             cnt_eff;
   logic [7:0]             payload;
   logic [7:0]             prbs_byte;

   // start only counts in IDLE, and a simultaneous stop cancels it.
   assign start_ok    = (state_q == IDLE) && start && !stop;
   assign beat        = tvalid_q && m_tready;
   // A new word may be loaded only when the output register is empty or draining.
   assign can_present = !tvalid_q || beat;

   // On the start cycle the first word comes straight from the live inputs,
   // since the config registers are only being written at that edge.
   assign mode_eff  = start_ok ? lpg_mode_t'(mode) : mode_q;
   assign fixed_eff = start_ok ? fixed_word : fixed_q;
   assign cnt_eff   = start_ok ? 8'h00 : cnt_q;

   always_comb begin
      payload = fixed_eff;
      case (mode_eff)
         MODE_COUNTER: payload = cnt_eff;
         MODE_PRBS7:   payload = prbs_byte;
         default:      payload = fixed_eff;
      endcase
   end

   // The LFSR steps whenever a payload word is loaded; in non-PRBS modes the
   // extra stepping is harmless because every start reseeds it.
   assign prbs_adv = present_payload;

   prbs7_byte_gen #(
      .SEED (PRBS_SEED)
   ) u_prbs (
      .clk    (in_clk160),
      .rst_n  (in_clk160_aresetn),
      .load   (start_ok),
      .adv    (prbs_adv),
      .byte_o (prbs_byte)
   );

   always_comb begin
      state_d         = state_q;
      mode_d          = mode_q;
      fixed_d         = fixed_q;
      train_word_d    = train_word_q;
      n_words_d       = n_words_q;
      data_rem_d      = data_rem_q;
      word_count_d    = word_count_q;
      train_rem_d     = train_rem_q;
      cnt_d           = cnt_q;
      tdata_d         = tdata_q;
      tvalid_d        = tvalid_q;
      busy_d          = busy_q;
      done_d          = 1'b0;
      present_payload = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_ok) begin
               mode_d       = lpg_mode_t'(mode);
               fixed_d      = fixed_word;
               train_word_d = train_word;
               n_words_d    = n_words;
               word_count_d = '0;
               busy_d       = 1'b1;
               tvalid_d     = 1'b1;
               if (n_train != '0) begin
                  state_d     = TRAIN;
                  tdata_d     = train_word;
                  train_rem_d = n_train - TRAIN_WIDTH'(1);
               end else begin
                  state_d         = DATA;
                  tdata_d         = payload;
                  present_payload = 1'b1;
                  data_rem_d      = n_words - COUNT_WIDTH'(1);
               end
            end
         end

         TRAIN: begin
            if (can_present) begin
               if (stop) begin
                  tvalid_d = 1'b0;
                  busy_d   = 1'b0;
                  state_d  = IDLE;
               end else if (train_rem_q != '0) begin
                  tdata_d     = train_word_q;
                  tvalid_d    = 1'b1;
                  train_rem_d = train_rem_q - TRAIN_WIDTH'(1);
               end else begin
                  // Last preamble beat: first payload word follows with no bubble.
                  state_d         = DATA;
                  tdata_d         = payload;
                  tvalid_d        = 1'b1;
                  present_payload = 1'b1;
                  data_rem_d      = n_words_q - COUNT_WIDTH'(1);
               end
            end
         end

         DATA: begin
            if (beat && (word_count_q != {COUNT_WIDTH{1'b1}})) begin
               word_count_d = word_count_q + COUNT_WIDTH'(1);
            end
            if (can_present) begin
               if (stop) begin
                  tvalid_d = 1'b0;
                  busy_d   = 1'b0;
                  state_d  = IDLE;
               end else if ((n_words_q == '0) || (data_rem_q != '0)) begin
                  // n_words == 0 means run until stop; data_rem is then don't-care.
                  tdata_d         = payload;
                  tvalid_d        = 1'b1;
                  present_payload = 1'b1;
                  data_rem_d      = data_rem_q - COUNT_WIDTH'(1);
               end else begin
                  tvalid_d = 1'b0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  state_d  = DONE;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (present_payload) begin
         cnt_d = cnt_eff + 8'd1;
      end
   end

   always_ff @(posedge in_clk160 or negedge in_clk160_aresetn) begin
      if (!in_clk160_aresetn) begin
         state_q      <= IDLE;
         mode_q       <= MODE_FIXED;
         fixed_q      <= 8'h00;
         train_word_q <= 8'h00;
         n_words_q    <= '0;
         data_rem_q   <= '0;
         word_count_q <= '0;
         train_rem_q  <= '0;
         cnt_q        <= 8'h00;
         tdata_q      <= 8'h00;
         tvalid_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         fixed_q      <= fixed_d;
         train_word_q <= train_word_d;
         n_words_q    <= n_words_d;
         data_rem_q   <= data_rem_d;
         word_count_q <= word_count_d;
         train_rem_q  <= train_rem_d;
         cnt_q        <= cnt_d;
         tdata_q      <= tdata_d;
         tvalid_q     <= tvalid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign m_tdata    = tdata_q;
   assign m_tvalid   = tvalid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign word_count = word_count_q;

endmodule
